apb_mem_responder: RTL and testbench

APB completer (slave) memory that serves the CPU fetch/data master over the 16-bit APB bus. It decodes a word-addressed window, inserts a programmable number of wait states, and completes reads and writes with PREADY. It flags out-of-window accesses with PSLVERR. A backdoor load port lets the testbench or boot logic preload program words.

---
 rtl/apb_mem_responder_if.sv | 24 ++
 rtl/apb_mem_responder.sv | 150 +++++++++++++++
 tb/tb_apb_mem_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_responder_if.sv
// APB bus bundle between the fetch/data master and the memory completer.
interface apb_mem_responder_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_responder.sv
// APB completer backed by a word-addressed memory window with programmable
// wait states, out-of-window error response and a backdoor preload port.
module apb_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned IDX_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    apb_mem_responder_if.slave   bus,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_addr,
    input  logic [15:0]          ld_data
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               write_q,    write_d;
    logic [DATA_W-1:0]  wdata_q,    wdata_d;
    logic               in_range_q, in_range_d;
    logic [DATA_W-1:0]  prdata_q,   prdata_d;
    logic               pready_q,   pready_d;
    logic               pslverr_q,  pslverr_d;
    logic               mem_we_c;

    // Extra top bit of the offset catches addresses below the window base.
    logic [ADDR_W:0]    offset_c;
    logic               in_range_c;

    assign offset_c   = {1'b0, bus.paddr} - {1'b0, BASE_ADDR};
    assign in_range_c = !offset_c[ADDR_W] && (offset_c[ADDR_W-1:0] < ADDR_W'(DEPTH));

    // Next-state, capture and response logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        in_range_d = in_range_q;
        prdata_d   = prdata_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        mem_we_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prdata_d  = '0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (bus.psel) begin
                    idx_d      = offset_c[IDX_W-1:0];
                    write_d    = bus.pwrite;
                    wdata_d    = bus.pwdata;
                    in_range_d = in_range_c;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bus.penable) begin
                    state_d  = ST_RESP;
                    pready_d = 1'b1;
                    if (!in_range_q) begin
                        prdata_d  = '0;
                        pslverr_d = 1'b1;
                    end else begin
                        pslverr_d = 1'b0;
                        if (write_q) begin
                            mem_we_c = 1'b1;
                            prdata_d = '0;
                        end else begin
                            prdata_d = mem[idx_q];
                        end
                    end
                end
            end
            ST_RESP: begin
                if (!(bus.psel && bus.penable)) begin
                    state_d   = ST_IDLE;
                    prdata_d  = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                prdata_d  = '0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            in_range_q <= in_range_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    // Memory is never reset; the APB write is ordered last so it wins a collision.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (reset && mem_we_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Directed bench: one responder with WAIT_CYCLES=1, one with WAIT_CYCLES=4,
// selected by tgt and sharing reset, address/data and backdoor stimulus.
module tb_apb_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        tgt;
    logic        psel, penable, pwrite;
    logic [15:0] paddr, pwdata;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    logic        obs_pready, obs_pslverr;
    logic [15:0] obs_prdata;

    int n_assert = 0;
    int n_fail   = 0;

    apb_mem_responder_if b1();
    apb_mem_responder_if b4();

    assign b1.psel    = psel & ~tgt;
    assign b1.penable = penable & ~tgt;
    assign b1.pwrite  = pwrite;
    assign b1.paddr   = paddr;
    assign b1.pwdata  = pwdata;
    assign b4.psel    = psel & tgt;
    assign b4.penable = penable & tgt;
    assign b4.pwrite  = pwrite;
    assign b4.paddr   = paddr;
    assign b4.pwdata  = pwdata;

    assign obs_pready  = tgt ? b4.pready  : b1.pready;
    assign obs_pslverr = tgt ? b4.pslverr : b1.pslverr;
    assign obs_prdata  = tgt ? b4.prdata  : b1.prdata;

    apb_mem_responder #(.DEPTH(256), .BASE_ADDR(16'h0000), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    apb_mem_responder #(.DEPTH(256), .BASE_ADDR(16'h0000), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // One APB transfer: setup, access until pready (bounded), optional hold, release.
    task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold, input logic b2b,
                        input logic chk_rd, input logic [15:0] exp_rd, input logic exp_err,
                        input int exp_lat, input logic coll, input logic [15:0] coll_data);
        int lat;
        logic [15:0] rd0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        tick();
        penable = 1'b1;
        lat = 0;
        while (lat < 20) begin
            if (coll && lat == exp_lat - 1) begin
                ld_en = 1'b1; ld_addr = addr[7:0]; ld_data = coll_data;
            end
            tick();
            ld_en = 1'b0;
            lat++;
            if (obs_pready === 1'b1) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(obs_pslverr), 32'(exp_err));
        if (chk_rd) chk({tag, "_rdata"}, 32'(obs_prdata), 32'(exp_rd));
        rd0 = obs_prdata;
        if (wr) begin
            pwdata = 16'hFFFF;
            paddr  = addr + 16'd1;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_rdy"}, 32'(obs_pready), 32'd1);
            chk({tag, "_hold_data"}, 32'(obs_prdata), 32'(rd0));
        end
        penable = 1'b0;
        if (!b2b) psel = 1'b0;
        tick();
        chk({tag, "_idle_rdy"}, 32'(obs_pready), 32'd0);
        chk({tag, "_idle_data"}, 32'(obs_prdata), 32'd0);
        chk({tag, "_idle_err"}, 32'(obs_pslverr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with psel asserted and a backdoor load during reset.
        reset = 1'b0; tgt = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0009; pwdata = 16'h0;
        ld_en = 1'b1; ld_addr = 8'd9; ld_data = 16'hC0DE;
        tick();
        ld_en = 1'b0; penable = 1'b1;
        chk("rst1_rdy", 32'(obs_pready), 32'd0);
        chk("rst1_err", 32'(obs_pslverr), 32'd0);
        chk("rst1_data", 32'(obs_prdata), 32'd0);
        tick();
        chk("rst2_rdy", 32'(obs_pready), 32'd0);
        chk("rst2_err", 32'(obs_pslverr), 32'd0);
        chk("rst2_data", 32'(obs_prdata), 32'd0);
        reset = 1'b1; psel = 1'b0; penable = 1'b0;
        tick();
        xfer("rd_preload", 1'b0, 16'h0009, 16'h0, 0, 1'b0, 1'b1, 16'hC0DE, 1'b0, 2, 1'b0, 16'h0);

        // Basic read with late sampling.
        bd(8'd5, 16'hA5C3);
        xfer("rd5", 1'b0, 16'h0005, 16'h0, 3, 1'b0, 1'b1, 16'hA5C3, 1'b0, 2, 1'b0, 16'h0);

        // Write held past pready while pwdata/paddr change.
        xfer("wr7", 1'b1, 16'h0007, 16'h1234, 3, 1'b0, 1'b0, 16'h0, 1'b0, 2, 1'b0, 16'h0);
        xfer("rd7", 1'b0, 16'h0007, 16'h0, 0, 1'b0, 1'b1, 16'h1234, 1'b0, 2, 1'b0, 16'h0);
        xfer("rd8", 1'b0, 16'h0008, 16'h0, 0, 1'b0, 1'b0, 16'h0, 1'b0, 2, 1'b0, 16'h0);

        // Window boundaries and out-of-range error.
        bd(8'd0, 16'h0011);
        bd(8'd1, 16'h0022);
        bd(8'd255, 16'h7777);
        xfer("rd_ff", 1'b0, 16'h00FF, 16'h0, 0, 1'b0, 1'b1, 16'h7777, 1'b0, 2, 1'b0, 16'h0);
        xfer("rd_100", 1'b0, 16'h0100, 16'h0, 1, 1'b0, 1'b1, 16'h0000, 1'b1, 2, 1'b0, 16'h0);
        xfer("wr_100", 1'b1, 16'h0100, 16'hDEAD, 0, 1'b0, 1'b0, 16'h0, 1'b1, 2, 1'b0, 16'h0);
        xfer("rd_ffff", 1'b0, 16'hFFFF, 16'h0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 2, 1'b0, 16'h0);

        // Back-to-back reads of 0 then 1 with psel held.
        xfer("b2b_0", 1'b0, 16'h0000, 16'h0, 0, 1'b1, 1'b1, 16'h0011, 1'b0, 2, 1'b0, 16'h0);
        xfer("b2b_1", 1'b0, 16'h0001, 16'h0, 0, 1'b0, 1'b1, 16'h0022, 1'b0, 2, 1'b0, 16'h0);

        // Backdoor collisions on the completion edge.
        xfer("coll_wr", 1'b1, 16'h0020, 16'hAAAA, 0, 1'b0, 1'b0, 16'h0, 1'b0, 2, 1'b1, 16'h5555);
        xfer("coll_wr_rb", 1'b0, 16'h0020, 16'h0, 0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 2, 1'b0, 16'h0);
        bd(8'h21, 16'h1111);
        xfer("coll_rd", 1'b0, 16'h0021, 16'h0, 0, 1'b0, 1'b1, 16'h1111, 1'b0, 2, 1'b1, 16'h2222);
        xfer("coll_rd_rb", 1'b0, 16'h0021, 16'h0, 0, 1'b0, 1'b1, 16'h2222, 1'b0, 2, 1'b0, 16'h0);

        // WAIT_CYCLES=4 responder: abort by psel drop.
        tgt = 1'b1;
        bd(8'd3, 16'h0303);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0003; pwdata = 16'hBEEF;
        tick();
        penable = 1'b1;
        tick();
        chk("abort_w1", 32'(obs_pready), 32'd0);
        tick();
        chk("abort_w2", 32'(obs_pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_after", 32'(obs_pready), 32'd0);
        end
        xfer("abort_rb", 1'b0, 16'h0003, 16'h0, 0, 1'b0, 1'b1, 16'h0303, 1'b0, 5, 1'b0, 16'h0);

        // Abort by reset during WAIT.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0003; pwdata = 16'hBEEF;
        tick();
        penable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rstw_rdy", 32'(obs_pready), 32'd0);
        chk("rstw_data", 32'(obs_prdata), 32'd0);
        reset = 1'b1; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstw_after", 32'(obs_pready), 32'd0);
        end
        xfer("rstw_rb", 1'b0, 16'h0003, 16'h0, 0, 1'b0, 1'b1, 16'h0303, 1'b0, 5, 1'b0, 16'h0);

        // Normal transfers on the slow responder afterwards.
        xfer("w4_wr", 1'b1, 16'h0003, 16'hBEEF, 1, 1'b0, 1'b0, 16'h0, 1'b0, 5, 1'b0, 16'h0);
        xfer("w4_rd", 1'b0, 16'h0003, 16'h0, 2, 1'b0, 1'b1, 16'hBEEF, 1'b0, 5, 1'b0, 16'h0);
        xfer("w4_oor", 1'b0, 16'h0200, 16'h0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 5, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
